branch_predictor_bht: RTL
=========================

Name: branch_predictor_bht

Overview:
Parametrised dynamic branch predictor for the single-cycle MIPS datapath. It replaces the fixed branch/jump statistics counter with two parts. The first is a tagged branch history table of saturating counters with stored targets, with optional gshare indexing. The second is a set of prediction-accuracy counters. It is looked up combinationally from the fetch PC, and updated at branch resolution in the same cycle. Statistics feed the display mux.

Parameters:
ENTRIES, 64, number of table entries; power of two, 4..1024
IDX_W, $clog2(ENTRIES), index width (derived; not overridden)
TAG_W, 8, tag bits taken above the index bits
CTR_W, 2, saturating counter width; 1..3
HIST_W, 0, global history length; 0 = bimodal, >0 = gshare (HIST_W <= IDX_W)
STAT_W, 16, width of each statistics counter

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
en  in  1  CPU running (clock-adjust state = run); 0 freezes all state
lookup_pc  in  32  PC of the instruction being fetched
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  32  predicted next PC
upd_valid  in  1  a conditional branch resolves this cycle
upd_pc  in  32  PC of the resolving branch
upd_taken  in  1  actual outcome
upd_target  in  32  actual taken target
upd_pred_taken  in  1  prediction made for this branch (echoed back)
upd_pred_target  in  32  predicted target made for this branch (echoed back)
clr_stats  in  1  clear statistics only
cnt_branch  out  STAT_W  resolved branches
cnt_taken  out  STAT_W  taken branches
cnt_correct  out  STAT_W  correct predictions
cnt_mispredict  out  STAT_W  mispredictions

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2] XOR {ghr zero-extended to IDX_W}; when HIST_W=0, ghr is absent.
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup (combinational, zero latency):
  - pred_hit = valid[idx] & (tag_mem[idx]==tag).
  - pred_taken = pred_hit & ctr[idx][CTR_W-1].
  - pred_target = target[idx] when pred_taken, else lookup_pc+4 (mod 2^32).
- Update fires only when upd_valid & en & !RST; it is applied at the CLK edge.
  - On hit for upd_pc:
    - taken: increment ctr, saturating at 2^CTR_W-1.
    - not taken: decrement ctr, saturating at 0.
    - taken: also write target.
  - On miss, taken: allocate or replace the entry. Set valid=1, write tag and target, ctr = 2^(CTR_W-1) (weakly taken).
  - On miss, not taken: no table write.
  - GHR (HIST_W>0): shift left, LSB = upd_taken. The update index uses the GHR value before the shift.
- Same-cycle lookup and update to the same entry: lookup returns the old contents (read-before-write).
- Statistics, on each qualified update:
  - cnt_branch +1.
  - cnt_taken +1 if upd_taken.
  - correct = (upd_pred_taken==upd_taken) & (!upd_taken | upd_pred_target==upd_target).
  - cnt_correct +1 if correct, otherwise cnt_mispredict +1.
  - Every counter saturates at 2^STAT_W-1; there is no wrap.
- clr_stats zeroes all four statistics counters. It has priority over an increment in the same cycle. Table and GHR are untouched.
- RST, including mid-run, at the next CLK edge:
  - all valid=0 and all ctr = 2^(CTR_W-1)-1 (weakly not-taken);
  - ghr=0 and all statistics = 0.
  - Outputs after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, all cnt_*=0.
- en=0 holds table, GHR and statistics. clr_stats is honoured regardless of en.

Decomposition:
- Package bp_pkg holds:
  - function ctr_init(CTR_W);
  - function ctr_alloc(CTR_W);
  - localparam PC_STEP=4;
  - the shared statistics-index constants used by the display mux (0 branch, 1 taken, 2 correct, 3 mispredict).
- Sub-module bp_sat_counter (parametrised width; inc/dec/load/init): used per-entry for counter next-state and reused for the four statistics counters.

Test Plan:
1. Reset, then lookup_pc=0x40 (ENTRIES=16, CTR_W=2, HIST_W=0) -> pred_hit=0, pred_taken=0, pred_target=0x44; all cnt_*=0.
2. Branch 0x40→0x80 updated taken twice (ctr 10 then 11), then lookup 0x40 -> hit=1, taken=1, target=0x80. Then two not-taken updates (ctr 01) -> hit=1, taken=0, target=0x44.
3. Saturation: five taken updates on 0x40, then one not-taken -> pred_taken=1 (ctr 10). A fresh not-taken miss on 0x100 -> pred_hit stays 0.
4. Aliasing: allocate 0x40 taken; lookup 0x80 (same idx 0, different tag) -> hit=0. Taken update 0x80→0xC0 -> 0x80 hits with target 0xC0; 0x40 now misses.
5. Statistics (STAT_W=4): four updates with three correct -> branch=4, correct=3, mispredict=1. 20 updates -> cnt_branch=15 (saturated). clr_stats together with upd_valid -> all 0. en=0 plus upd_valid -> no change.
6. gshare (HIST_W=2) and RST mid-run:
   - Alternating T/N branch at 0x40 -> after warm-up, prediction correct every iteration.
   - Assert RST for one cycle -> lookup 0x40 gives hit=0; ghr and counters are 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch history table predictor.
// The statistics indices are also used by the display mux.
package bp_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  localparam int unsigned STAT_BRANCH     = 0;
  localparam int unsigned STAT_TAKEN      = 1;
  localparam int unsigned STAT_CORRECT    = 2;
  localparam int unsigned STAT_MISPREDICT = 3;
  localparam int unsigned STAT_NUM        = 4;

  // Weakly not-taken: the value every counter returns to on reset.
  function automatic int unsigned ctr_init(int unsigned ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

  // Weakly taken: the value a newly allocated entry starts with.
  function automatic int unsigned ctr_alloc(int unsigned ctr_w);
    return 32'd1 << (ctr_w - 1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a saturating up/down counter.
// Priority: init, then load, then inc/dec. Inc together with dec holds.
module bp_sat_counter #(
  parameter int unsigned Width   = 2,
  parameter int unsigned InitVal = 0
) (
  input  logic [Width-1:0] q,
  input  logic             init,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] d
);

  localparam logic [Width-1:0] MaxVal = '1;

  always_comb begin
    d = q;
    if (init) begin
      d = Width'(InitVal);
    end else if (load) begin
      d = load_val;
    end else if (inc && !dec) begin
      if (q != MaxVal) d = q + 1'b1;
    end else if (dec && !inc) begin
      if (q != '0) d = q - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Tagged branch history table with optional gshare indexing, zero-latency lookup,
// same-cycle update at resolution, and saturating prediction-accuracy statistics.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 0,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  input  logic              clr_stats,
  output logic [STAT_W-1:0] cnt_branch,
  output logic [STAT_W-1:0] cnt_taken,
  output logic [STAT_W-1:0] cnt_correct,
  output logic [STAT_W-1:0] cnt_mispredict
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  // Keep a 1-bit history register in bimodal mode so widths stay legal; it stays 0.
  localparam int unsigned GHR_W = (HIST_W > 0) ? HIST_W : 1;
  localparam logic [CTR_W-1:0] CtrInit  = CTR_W'(ctr_init(CTR_W));
  localparam logic [CTR_W-1:0] CtrAlloc = CTR_W'(ctr_alloc(CTR_W));

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic [IDX_W-1:0] ghr_idx, lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, qual, correct;
  logic [CTR_W-1:0] ctr_nxt;

  assign ghr_idx = IDX_W'(ghr_q);
  assign lk_idx  = lookup_pc[IDX_W+1:2] ^ ghr_idx;
  assign lk_tag  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx  = upd_pc[IDX_W+1:2] ^ ghr_idx;
  assign up_tag  = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign qual    = upd_valid && en;
  assign ghr_d   = GHR_W'({ghr_q, upd_taken});

  // Lookup reads the registered table, so a same-cycle update is not visible here.
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_STEP;

  // A miss can only reach the write path when taken, so load means allocate.
  bp_sat_counter #(
    .Width  (CTR_W),
    .InitVal(ctr_init(CTR_W))
  ) u_ctr_next (
    .q       (ctr_q[up_idx]),
    .init    (1'b0),
    .load    (!up_hit),
    .load_val(CtrAlloc),
    .inc     (upd_taken),
    .dec     (!upd_taken),
    .d       (ctr_nxt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CtrInit;
      end
      ghr_q <= '0;
    end else if (qual) begin
      if (up_hit || upd_taken) ctr_q[up_idx] <= ctr_nxt;
      if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
      end
      if (HIST_W > 0) ghr_q <= ghr_d;
    end
  end

  logic [STAT_W-1:0]   stat_q [STAT_NUM];
  logic [STAT_W-1:0]   stat_d [STAT_NUM];
  logic [STAT_NUM-1:0] stat_inc;

  // Taken branches must also match the target to count as correct.
  assign correct  = (upd_pred_taken == upd_taken) &&
                    (!upd_taken || (upd_pred_target == upd_target));
  assign stat_inc = {qual && !correct, qual && correct, qual && upd_taken, qual};

  for (genvar g = 0; g < STAT_NUM; g++) begin : gen_stat
    bp_sat_counter #(
      .Width  (STAT_W),
      .InitVal(0)
    ) u_stat (
      .q       (stat_q[g]),
      .init    (clr_stats),
      .load    (1'b0),
      .load_val('0),
      .inc     (stat_inc[g]),
      .dec     (1'b0),
      .d       (stat_d[g])
    );
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < STAT_NUM; i++) begin
      stat_q[i] <= RST ? '0 : stat_d[i];
    end
  end

  assign cnt_branch     = stat_q[STAT_BRANCH];
  assign cnt_taken      = stat_q[STAT_TAKEN];
  assign cnt_correct    = stat_q[STAT_CORRECT];
  assign cnt_mispredict = stat_q[STAT_MISPREDICT];

endmodule
